pdm_decimator: RTL and testbench

PDM microphone front end: generates the PDM bit clock for a 1-bit MEMS microphone, samples its bitstream, and decimates it to PCM with a 2nd-order CIC filter. It is the receive-side counterpart of the `pdm` encoder that drives the speakers. It runs on the 98.304 MHz audio clock and supplies `audio_data` samples to the downstream FFT/biometrics path.

---
 rtl/pdm_decimator.sv | 140 ++++++++++++++
 tb/tb_pdm_decimator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// PDM mic front end: bit clock, 2-flop input sync, 2nd-order CIC decimator.
// clk_in/rst_in, mic_data_in -> mic_clk_out, sample_out, audio_out, sample_valid_out.
module pdm_decimator #(
  parameter  int CLK_DIV = 32,
  parameter  int DECIM   = 64,
  localparam int LD      = $clog2(DECIM),
  localparam int W       = 2 * LD + 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                mic_data_in,
  output logic                mic_clk_out,
  output logic signed [W-1:0] sample_out,
  output logic signed [7:0]   audio_out,
  output logic                sample_valid_out
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int SH = 2 * LD - 7;

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [LD-1:0] DCNT_MAX = LD'(DECIM - 1);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] NEG_ONE = '1;

  localparam logic signed [W-1:0] A_MAX = W'(127);
  localparam logic signed [W-1:0] A_MIN = -W'(128);

  logic [CW-1:0] cnt;
  logic [LD-1:0] dcnt;

  logic sync1;
  logic sync2;

  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i2_d;
  logic [W-1:0] c1;
  logic [W-1:0] c1_d;
  logic [W-1:0] c2;

  // frame-end tick pipelined through the two comb stages
  logic fe1;
  logic fe2;
  logic fe3;

  logic                tick;
  logic                frame_end;
  logic [W-1:0]        x;
  logic [W-1:0]        c2_next;
  logic signed [W-1:0] c2_sh;
  logic [7:0]          audio_next;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (dcnt == DCNT_MAX);

  always_comb begin
    x       = sync2 ? ONE : NEG_ONE;
    c2_next = c1 - c1_d;
    c2_sh   = $signed(c2_next) >>> SH;
    audio_next = c2_sh[7:0];
    if (c2_sh > A_MAX) begin
      audio_next = 8'h7f;
    end else if (c2_sh < A_MIN) begin
      audio_next = 8'h80;
    end
  end

  // bit clock and input sampling
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt         <= '0;
      mic_clk_out <= 1'b0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      mic_clk_out <= (cnt < CNT_HALF);
      sync1       <= mic_data_in;
      sync2       <= sync1;
    end
  end

  // integrators run at the PDM bit rate; wraparound is intended
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i1   <= '0;
      i2   <= '0;
      dcnt <= '0;
      fe1  <= 1'b0;
    end else begin
      fe1 <= frame_end;
      if (tick) begin
        i1   <= i1 + x;
        i2   <= i2 + i1;
        dcnt <= dcnt + LD'(1);
      end
    end
  end

  // comb stages run once per frame
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i2_d <= '0;
      c1   <= '0;
      c1_d <= '0;
      c2   <= '0;
      fe2  <= 1'b0;
      fe3  <= 1'b0;
    end else begin
      fe2 <= fe1;
      fe3 <= fe2;
      if (fe1) begin
        c1   <= i2 - i2_d;
        i2_d <= i2;
      end
      if (fe2) begin
        c2   <= c2_next;
        c1_d <= c1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      audio_out        <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= fe3;
      if (fe2) begin
        audio_out <= audio_next;
      end
    end
  end

  assign sample_out = c2;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator at default parameters.
// Drives per-tick bit patterns and checks strobe timing and CIC outputs.
module tb_pdm_decimator;

  localparam int CLK_DIV = 32;
  localparam int W       = 14;
  localparam int FRAME   = 2048;
  localparam int LAT     = 2050;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic                mic_data_in = 1'b0;
  logic                mic_clk_out;
  logic signed [W-1:0] sample_out;
  logic signed [7:0]   audio_out;
  logic                sample_valid_out;

  pdm_decimator dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .mic_data_in      (mic_data_in),
    .mic_clk_out      (mic_clk_out),
    .sample_out       (sample_out),
    .audio_out        (audio_out),
    .sample_valid_out (sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  int          n = 0;
  int          cur_k = 0;
  bit          cur_bit = 1'b0;
  int          mode = 0;
  logic [15:0] lfsr = 16'hACE1;
  bit          hist[$];
  int          timing_err = 0;
  bit          got_strobe = 1'b0;
  int          last_edge = -1;
  int          exp_y = 0;
  int          exp_a = 0;

  function automatic bit gen_bit(int k);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return k[0];
      3: return (k % 4) != 0;
      default: begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        return lfsr[0] | lfsr[1];
      end
    endcase
  endfunction

  // CIC2 as a triangular FIR over the last 128 bits since reset
  task automatic model(output int y, output int a);
    int nb;
    int d;
    int w;
    nb = hist.size();
    y = 0;
    for (int j = (nb > 128 ? nb - 128 : 0); j < nb; j++) begin
      d = nb - 1 - j;
      w = (d <= 64) ? d : 128 - d;
      y += hist[j] ? w : -w;
    end
    a = y >>> 5;
    if (a > 127) a = 127;
    if (a < -128) a = -128;
  endtask

  task automatic step();
    int k;
    bit ev;
    k = n / CLK_DIV + 1;
    if (k != cur_k) begin
      cur_bit = gen_bit(k);
      cur_k = k;
    end
    mic_data_in = cur_bit;
    @(posedge clk_in);
    #1;
    got_strobe = sample_valid_out;
    if (rst_in) begin
      n = 0;
      cur_k = 0;
      hist.delete();
      if (sample_valid_out !== 1'b0) timing_err++;
    end else begin
      if (n % CLK_DIV == CLK_DIV - 1) hist.push_back(cur_bit);
      ev = (n >= LAT) && ((n - LAT) % FRAME == 0);
      if (ev) model(exp_y, exp_a);
      if (got_strobe) last_edge = n;
      if (sample_valid_out !== ev) timing_err++;
      n++;
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME + 100; i++) begin
      step();
      if (got_strobe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cyc);
    rst_in = 1'b1;
    repeat (cyc) step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    mode = 1;
    do_reset(3);
    repeat (700) step();
    rst_in = 1'b1;
    repeat (5) step();
    checks++;
    if (sample_out !== '0) begin
      errors++;
      $display("FAIL reset_sample got %0d want 0", sample_out);
    end
    checks++;
    if (audio_out !== '0) begin
      errors++;
      $display("FAIL reset_audio got %0d want 0", audio_out);
    end
    checks++;
    if (sample_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", sample_valid_out);
    end
    checks++;
    if (mic_clk_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_micclk got %b want 0", mic_clk_out);
    end
    rst_in = 1'b0;
    timing_err = 0;
    wait_strobe(ok);
    checks++;
    if (!ok || last_edge != LAT) begin
      errors++;
      $display("FAIL reset_first_strobe got edge %0d want %0d", last_edge, LAT);
    end
    checks++;
    if (timing_err != 0) begin
      errors++;
      $display("FAIL reset_timing got %0d bad cycles want 0", timing_err);
    end
  endtask

  task automatic test_const(input bit v);
    bit ok;
    int es[3];
    int ea[3];
    logic signed [W-1:0] held;
    if (v) begin
      es = '{2016, 4096, 4096};
      ea = '{63, 127, 127};
    end else begin
      es = '{-2016, -4096, -4096};
      ea = '{-63, -128, -128};
    end
    mode = v ? 1 : 0;
    do_reset(4);
    timing_err = 0;
    for (int s = 0; s < 3; s++) begin
      wait_strobe(ok);
      checks++;
      if (!ok || sample_out !== W'(es[s])) begin
        errors++;
        $display("FAIL const%0d_s%0d sample got %0d want %0d", v, s + 1, sample_out, es[s]);
      end
      checks++;
      if (!ok || audio_out !== 8'(ea[s])) begin
        errors++;
        $display("FAIL const%0d_s%0d audio got %0d want %0d", v, s + 1, audio_out, ea[s]);
      end
      if (s == 0) begin
        held = sample_out;
        repeat (500) step();
        checks++;
        if (sample_out !== W'(es[0])) begin
          errors++;
          $display("FAIL const%0d_hold got %0d want %0d", v, sample_out, es[0]);
        end
      end
    end
    checks++;
    if (timing_err != 0) begin
      errors++;
      $display("FAIL const%0d_timing got %0d bad cycles want 0", v, timing_err);
    end
  endtask

  task automatic test_alternating();
    bit ok;
    int prev;
    int highs;
    int phase_err;
    mode = 2;
    do_reset(4);
    timing_err = 0;
    highs = 0;
    phase_err = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (mic_clk_out === 1'b1) highs++;
      if (mic_clk_out !== (((n - 1) % CLK_DIV) < 16)) phase_err++;
    end
    checks++;
    if (highs != 32 || phase_err != 0) begin
      errors++;
      $display("FAIL micclk got %0d high %0d phase_err want 32 high 0", highs, phase_err);
    end
    wait_strobe(ok);
    checks++;
    if (!ok || sample_out !== W'(32) || audio_out !== 8'(1)) begin
      errors++;
      $display("FAIL alt_s1 got %0d/%0d want 32/1", sample_out, audio_out);
    end
    prev = last_edge;
    step();
    checks++;
    if (sample_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width got %b want 0", sample_valid_out);
    end
    for (int s = 2; s <= 4; s++) begin
      wait_strobe(ok);
      checks++;
      if (!ok || sample_out !== '0 || audio_out !== '0) begin
        errors++;
        $display("FAIL alt_s%0d got %0d/%0d want 0/0", s, sample_out, audio_out);
      end
      checks++;
      if (last_edge - prev != FRAME) begin
        errors++;
        $display("FAIL spacing got %0d want %0d", last_edge - prev, FRAME);
      end
      prev = last_edge;
    end
    checks++;
    if (timing_err != 0) begin
      errors++;
      $display("FAIL alt_timing got %0d bad cycles want 0", timing_err);
    end
  endtask

  task automatic test_density();
    bit ok;
    mode = 3;
    do_reset(4);
    wait_strobe(ok);
    for (int s = 2; s <= 3; s++) begin
      wait_strobe(ok);
      checks++;
      if (!ok || sample_out !== W'(2048) || audio_out !== 8'(64)) begin
        errors++;
        $display("FAIL density_s%0d got %0d/%0d want 2048/64", s, sample_out, audio_out);
      end
    end
  endtask

  task automatic test_lfsr();
    bit ok;
    int bad;
    mode = 4;
    do_reset(4);
    timing_err = 0;
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      wait_strobe(ok);
      checks++;
      if (!ok || sample_out !== W'(exp_y) || audio_out !== 8'(exp_a)) begin
        errors++;
        $display("FAIL lfsr_s%0d got %0d/%0d want %0d/%0d", s + 1, sample_out, audio_out, exp_y, exp_a);
      end
    end
    repeat (1000) step();
    do_reset(5);
    for (int s = 0; s < 4; s++) begin
      wait_strobe(ok);
      checks++;
      if (!ok || sample_out !== W'(exp_y) || audio_out !== 8'(exp_a)) begin
        errors++;
        $display("FAIL lfsr_rst_s%0d got %0d/%0d want %0d/%0d", s + 1, sample_out, audio_out, exp_y, exp_a);
      end
    end
    checks++;
    if (timing_err != 0) begin
      errors++;
      $display("FAIL lfsr_timing got %0d bad cycles want 0", timing_err);
    end
  endtask

  task automatic test_reset_on_tick();
    int seen;
    mode = 1;
    do_reset(4);
    while (n < LAT - 3) step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sample_valid_out !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || sample_out !== '0) begin
      errors++;
      $display("FAIL rst_on_tick got %0d strobes sample %0d want 0 0", seen, sample_out);
    end
  endtask

  initial begin
    test_reset();
    test_const(1'b1);
    test_const(1'b0);
    test_alternating();
    test_density();
    test_lfsr();
    test_reset_on_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
